down_timer: RTL and testbench

//  Loadable down-counting timer. It is the count-down counterpart of the free-running up-counter.
//  A start value is written over a valid/ready load handshake. The timer is armed, then started.
//  It decrements once per unpaused clock and pulses o_done on reaching terminal count.

---
 rtl/down_timer.sv | 108 ++++++++++
 tb/tb_down_timer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counting timer: load over a valid/ready handshake, arm, start,
// count to terminal, pulse o_done, optionally auto-reload for a periodic tick.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_load_ready,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_auto_reload,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_done_nxt;
  logic             w_load_ready;
  logic             w_load_acc;

  // Load handshake: a transfer happens on a rising edge where both
  // i_load_valid and o_load_ready are high; ready drops for the whole RUN
  // state, and a request offered then is simply dropped, never queued.
  assign w_load_ready = (r_state != ST_RUN);
  assign w_load_acc   = i_load_valid && w_load_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load_acc) begin
          w_count_nxt  = i_load_value;
          w_reload_nxt = i_load_value;
          if (i_load_value != '0) w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_load_acc) begin
          w_count_nxt  = i_load_value;
          w_reload_nxt = i_load_value;
        end else if (i_start) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_pause) begin
          if (r_count > WIDTH'(1)) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else begin
            // Terminal edge: reload skips the zero count entirely.
            w_done_nxt = 1'b1;
            if (i_auto_reload) begin
              w_count_nxt = r_reload;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign o_load_ready = w_load_ready;
  assign o_count      = r_count;
  assign o_busy       = (r_state == ST_RUN);
  assign o_done       = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios with literal expectations plus
// randomized traffic, all outputs checked every cycle against a timer model.
module tb_down_timer;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 3;

  logic             i_clk;
  logic             i_reset;
  logic             i_load_valid;
  logic [WIDTH-1:0] i_load_value;
  logic             o_load_ready;
  logic             i_start;
  logic             i_pause;
  logic             i_auto_reload;
  logic [WIDTH-1:0] o_count;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_dbg_state;

  int checks   = 0;
  int failures = 0;

  down_timer #(.WIDTH(WIDTH)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_load_valid  (i_load_valid),
    .i_load_value  (i_load_value),
    .o_load_ready  (o_load_ready),
    .i_start       (i_start),
    .i_pause       (i_pause),
    .i_auto_reload (i_auto_reload),
    .o_count       (o_count),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // The timer holds a value, a remembered period, and whether it is counting
  // or waiting for a start (has_value). Expected outputs are pushed per edge.
  int  m_value   = 0;
  int  m_period  = 0;
  bit  m_running = 0;
  bit  m_has_val = 0;
  bit  m_pulse   = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge i_clk) begin
    m_pulse = 0;
    if (i_reset) begin
      m_value = 0; m_period = 0; m_running = 0; m_has_val = 0;
    end else if (m_running) begin
      if (!i_pause) begin
        if (m_value == 1) begin
          m_pulse = 1;
          if (i_auto_reload) m_value = m_period;
          else begin
            m_value = 0; m_running = 0; m_has_val = 0;
          end
        end else begin
          m_value = m_value - 1;
        end
      end
    end else if (i_load_valid) begin
      m_value  = i_load_value;
      m_period = i_load_value;
      if (!m_has_val) m_has_val = (i_load_value != 0);
    end else if (m_has_val && i_start) begin
      m_running = 1;
    end
    exp_q.push_back({WIDTH'(m_value), m_running, m_pulse, !m_running});
  end

  // ---------------- scoreboard ----------------
  always @(negedge i_clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {o_count, o_busy, o_done, o_load_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual{cnt,busy,done,rdy}=%0d,%0b,%0b,%0b required=%0d,%0b,%0b,%0b",
                 $time, a[W-1:3], a[2], a[1], a[0], e[W-1:3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1; tick(); tick(); i_reset = 1'b0;
  endtask

  task automatic load(input int v);
    i_load_valid = 1'b1; i_load_value = WIDTH'(v);
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (o_busy && n < max_cyc) begin tick(); n++; end
    check("wait_idle_timeout", int'(o_busy), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses, zeros, n;
    i_reset = 1'b1; i_load_valid = 1'b0; i_load_value = '0;
    i_start = 1'b0; i_pause = 1'b0; i_auto_reload = 1'b0;
    tick(); tick();
    check("reset_count", int'(o_count), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    check("reset_ready", int'(o_load_ready), 1);
    i_reset = 1'b0;

    // 1. basic countdown from 5
    load(5);
    check("s1_armed_ready", int'(o_load_ready), 1);
    start();
    check("s1_busy", int'(o_busy), 1);
    check("s1_cnt5", int'(o_count), 5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("s1_cnt_seq", int'(o_count), 5 - i);
    end
    check("s1_no_early_done", int'(o_done), 0);
    tick();
    check("s1_done", int'(o_done), 1);
    check("s1_cnt0", int'(o_count), 0);
    check("s1_idle_ready", int'(o_load_ready), 1);
    tick();
    check("s1_done_single", int'(o_done), 0);

    // 2. auto-reload period 3
    i_auto_reload = 1'b1;
    load(3);
    start();
    pulses = 0; zeros = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_done) pulses++;
      if (o_count == 0) zeros++;
    end
    check("s2_pulses", pulses, 4);
    check("s2_no_zero", zeros, 0);
    check("s2_reloaded", int'(o_count), 3);
    i_auto_reload = 1'b0;
    wait_idle(10);

    // 3. pause of 6 cycles after 2 decrements
    load(4);
    start();
    tick(); tick();
    check("s3_cnt_before_pause", int'(o_count), 2);
    i_pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("s3_hold", int'(o_count), 2);
    end
    i_pause = 1'b0;
    tick();
    check("s3_no_done_yet", int'(o_done), 0);
    tick();
    check("s3_done_at_10", int'(o_done), 1);

    // 4. reset mid-run at count 2
    load(6);
    start();
    for (int i = 0; i < 4; i++) tick();
    check("s4_cnt2", int'(o_count), 2);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    check("s4_cnt0", int'(o_count), 0);
    check("s4_busy0", int'(o_busy), 0);
    check("s4_no_done", int'(o_done), 0);
    tick();
    check("s4_no_done_later", int'(o_done), 0);

    // 5. handshake corners
    load(0);
    check("s5_zero_stays_idle", int'(o_busy), 0);
    check("s5_zero_no_done", int'(o_done), 0);
    start();
    check("s5_zero_no_run", int'(o_busy), 0);
    load(5);
    start();
    i_load_valid = 1'b1; i_load_value = 8'd7;
    check("s5_run_not_ready", int'(o_load_ready), 0);
    tick();
    check("s5_run_load_ignored", int'(o_count), 4);
    i_load_valid = 1'b0;
    wait_idle(10);
    load(3);
    i_load_valid = 1'b1; i_load_value = 8'd9; i_start = 1'b1;
    tick();
    i_load_valid = 1'b0;
    check("s5_load_wins_cnt", int'(o_count), 9);
    check("s5_load_wins_busy", int'(o_busy), 0);
    tick();
    i_start = 1'b0;
    check("s5_then_run", int'(o_busy), 1);
    wait_idle(15);

    // 6. full-scale load
    load(255);
    start();
    n = 0;
    while (!o_done && n < 300) begin tick(); n++; end
    check("s6_latency", n, 255);
    check("s6_cnt0", int'(o_count), 0);

    // randomized traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 3000; i++) begin
      i_reset       = ($urandom_range(0, 99) < 2);
      i_load_valid  = ($urandom_range(0, 99) < 30);
      i_load_value  = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom_range(1, 255))
                                                  : WIDTH'($urandom_range(1, 12));
      i_start       = ($urandom_range(0, 99) < 40);
      i_pause       = ($urandom_range(0, 99) < 20);
      i_auto_reload = $urandom_range(0, 1);
      tick();
    end
    i_reset = 1'b0; i_load_valid = 1'b0; i_start = 1'b0;
    i_pause = 1'b0; i_auto_reload = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
